// File: rtl/cgra_cfg_pkg.sv
// Shared types and defaults for the CGRA configuration sequencer.
package cgra_cfg_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_RUN_W      = 32;
    localparam int DEF_RST_CYCLES = 4;
    localparam int DEF_GAP_CYCLES = 0;
    localparam int WCOUNT_W       = 16;
    localparam int CRST_CNT_W     = 16;
    localparam int GAP_CNT_W      = 4;

    // Idle value of the CGRA config bus; never a legal write address.
    localparam int unsigned CFG_IDLE_ADDR = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_CONFIG,
        ST_GAP,
        ST_RUN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/cgra_cfg_down_counter.sv
// Loadable down counter with zero flag, used for the reset, gap and run phases.
module cgra_cfg_down_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load has priority over decrement; decrement holds at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/cgra_config_sequencer.sv
// CGRA bring-up sequencer: reset pulse, config write burst, run window, done.
module cgra_config_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int RUN_W      = DEF_RUN_W
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              start_in,
    input  logic [RUN_W-1:0]  run_cycles_in,
    input  logic              cfg_valid_in,
    output logic              cfg_ready_out,
    input  logic [ADDR_W-1:0] cfg_addr_in,
    input  logic [DATA_W-1:0] cfg_data_in,
    input  logic              cfg_last_in,
    output logic              cgra_reset_out,
    output logic [ADDR_W-1:0] config_addr_out,
    output logic [DATA_W-1:0] config_data_out,
    output logic              run_en_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [15:0]       word_count_out
);

    seq_state_t            r_state;
    seq_state_t            w_next;
    logic [RUN_W-1:0]      r_run_cycles;
    logic [ADDR_W-1:0]     r_cfg_addr;
    logic [DATA_W-1:0]     r_cfg_data;
    logic                  r_cgra_reset;
    logic                  r_run_en;
    logic                  r_err;
    logic [WCOUNT_W-1:0]   r_word_count;

    logic w_start_ok;
    logic w_hs;
    logic w_addr_ok;
    logic w_crst_load, w_gap_load, w_run_load;
    logic w_crst_zero, w_gap_zero, w_run_zero;

    assign w_start_ok = start_in && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_hs       = cfg_valid_in && (r_state == ST_CONFIG);
    assign w_addr_ok  = (cfg_addr_in != ADDR_W'(CFG_IDLE_ADDR));

    cgra_cfg_down_counter #(.W(CRST_CNT_W)) u_crst_cnt (
        .i_clk      (clk_in),
        .i_rst_n    (reset_n_in),
        .i_load     (w_crst_load),
        .i_load_val (CRST_CNT_W'(RST_CYCLES - 1)),
        .i_dec      (r_state == ST_CRST),
        .o_zero     (w_crst_zero)
    );

    cgra_cfg_down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
        .i_clk      (clk_in),
        .i_rst_n    (reset_n_in),
        .i_load     (w_gap_load),
        .i_load_val (GAP_CNT_W'(GAP_CYCLES - 1)),
        .i_dec      (r_state == ST_GAP),
        .o_zero     (w_gap_zero)
    );

    // Loaded with the full run length: the first RUN cycle carries the last
    // write on the bus, and run_en_out (registered) rises one cycle later.
    cgra_cfg_down_counter #(.W(RUN_W)) u_run_cnt (
        .i_clk      (clk_in),
        .i_rst_n    (reset_n_in),
        .i_load     (w_run_load),
        .i_load_val (r_run_cycles),
        .i_dec      (r_state == ST_RUN),
        .o_zero     (w_run_zero)
    );

    // State register.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and phase counter loads.
    always_comb begin
        w_next      = r_state;
        w_crst_load = 1'b0;
        w_gap_load  = 1'b0;
        w_run_load  = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_next      = ST_CRST;
                    w_crst_load = 1'b1;
                end
            end
            ST_CRST: begin
                if (w_crst_zero) w_next = ST_CONFIG;
            end
            ST_CONFIG: begin
                if (w_hs) begin
                    if (cfg_last_in) begin
                        w_next     = ST_RUN;
                        w_run_load = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        w_next     = ST_GAP;
                        w_gap_load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_gap_zero) w_next = ST_CONFIG;
            end
            ST_RUN: begin
                if (w_run_zero) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Run length latch, sticky zero-address error and saturating write count.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_run_cycles <= '0;
            r_err        <= 1'b0;
            r_word_count <= '0;
        end else if (w_start_ok) begin
            r_run_cycles <= run_cycles_in;
            r_err        <= 1'b0;
            r_word_count <= '0;
        end else if (w_hs) begin
            if (!w_addr_ok) begin
                r_err <= 1'b1;
            end else if (r_word_count != '1) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    // Registered signals into the CGRA so they are glitch-free.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_cfg_addr   <= '0;
            r_cfg_data   <= '0;
            r_cgra_reset <= 1'b0;
            r_run_en     <= 1'b0;
        end else begin
            r_cfg_addr   <= (w_hs && w_addr_ok) ? cfg_addr_in : '0;
            r_cfg_data   <= (w_hs && w_addr_ok) ? cfg_data_in : '0;
            r_cgra_reset <= (w_next == ST_CRST);
            r_run_en     <= (r_state == ST_RUN) && !w_run_zero;
        end
    end

    assign cfg_ready_out   = (r_state == ST_CONFIG);
    assign busy_out        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_out        = (r_state == ST_DONE);
    assign cgra_reset_out  = r_cgra_reset;
    assign config_addr_out = r_cfg_addr;
    assign config_data_out = r_cfg_data;
    assign run_en_out      = r_run_en;
    assign err_out         = r_err;
    assign word_count_out  = r_word_count;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Directed bench for cgra_config_sequencer: DUT A has no gap, DUT B has a 2-cycle gap.
module tb_cgra_config_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [31:0] run_cycles = '0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_last = 1'b0;

    logic        a_ready, a_crst, a_run, a_busy, a_done, a_err;
    logic [31:0] a_addr, a_data;
    logic [15:0] a_wc;
    logic        b_ready, b_crst, b_run, b_busy, b_done, b_err;
    logic [31:0] b_addr, b_data;
    logic [15:0] b_wc;

    cgra_config_sequencer #(.ADDR_W(32), .DATA_W(32), .RST_CYCLES(4), .GAP_CYCLES(0), .RUN_W(32)) u_dut_a (
        .clk_in(clk), .reset_n_in(reset_n), .start_in(start_a), .run_cycles_in(run_cycles),
        .cfg_valid_in(cfg_valid), .cfg_ready_out(a_ready), .cfg_addr_in(cfg_addr),
        .cfg_data_in(cfg_data), .cfg_last_in(cfg_last), .cgra_reset_out(a_crst),
        .config_addr_out(a_addr), .config_data_out(a_data), .run_en_out(a_run),
        .busy_out(a_busy), .done_out(a_done), .err_out(a_err), .word_count_out(a_wc)
    );

    cgra_config_sequencer #(.ADDR_W(32), .DATA_W(32), .RST_CYCLES(4), .GAP_CYCLES(2), .RUN_W(32)) u_dut_b (
        .clk_in(clk), .reset_n_in(reset_n), .start_in(start_b), .run_cycles_in(run_cycles),
        .cfg_valid_in(cfg_valid), .cfg_ready_out(b_ready), .cfg_addr_in(cfg_addr),
        .cfg_data_in(cfg_data), .cfg_last_in(cfg_last), .cgra_reset_out(b_crst),
        .config_addr_out(b_addr), .config_data_out(b_data), .run_en_out(b_run),
        .busy_out(b_busy), .done_out(b_done), .err_out(b_err), .word_count_out(b_wc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    // Monitored DUT selection
    bit          sel = 1'b0;
    logic        m_ready, m_crst, m_run, m_done, m_err, m_busy;
    logic [31:0] m_addr, m_data;
    logic [15:0] m_wc;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_crst  = sel ? b_crst  : a_crst;
    assign m_run   = sel ? b_run   : a_run;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_data  = sel ? b_data  : a_data;
    assign m_wc    = sel ? b_wc    : a_wc;

    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          rdy_cyc[$];
    int          rst_cnt = 0, rst_first = -1, run_cnt = 0, run_first = -1;

    always @(negedge clk) begin
        if (m_addr !== '0 || m_data !== '0) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(m_addr);
            wr_data.push_back(m_data);
        end
        if (m_ready === 1'b1) rdy_cyc.push_back(cyc);
        if (m_crst === 1'b1) begin
            if (rst_cnt == 0) rst_first = cyc;
            rst_cnt++;
        end
        if (m_run === 1'b1) begin
            if (run_cnt == 0) run_first = cyc;
            run_cnt++;
        end
    end

    logic [31:0] tw_addr[6];
    logic [31:0] tw_data[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sequence: start, feed n words from tw_* with a valid pattern, wait for done.
    task automatic run_seq(input string nm, input bit use_b, input logic [31:0] runc, input int n,
                           input logic [5:0] vpat, input bit poke_run,
                           output int s, output logic err_at_start, output logic [15:0] wc_at_start);
        int idx;
        int k;
        bit hs;
        bit poked;
        bit done_seen;
        sel = use_b;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); rdy_cyc.delete();
        rst_cnt = 0; rst_first = -1; run_cnt = 0; run_first = -1;
        run_cycles = runc;
        cfg_valid = 1'b0;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        s = cyc;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        err_at_start = m_err;
        wc_at_start = m_wc;
        idx = 0; k = 0;
        for (int c = 0; c < 200 && idx < n; c++) begin
            cfg_addr  = tw_addr[idx];
            cfg_data  = tw_data[idx];
            cfg_last  = (idx == n - 1);
            cfg_valid = (k < 6) ? vpat[k] : 1'b1;
            hs = m_ready && cfg_valid;
            if (m_ready) k++;
            tick();
            if (hs) idx++;
        end
        cfg_valid = 1'b0; cfg_last = 1'b0; cfg_addr = '0; cfg_data = '0;
        n_chk++;
        if (idx != n) begin n_bad++; $display("FAIL %s_handshakes got=%0d exp=%0d", nm, idx, n); end
        done_seen = 1'b0; poked = 1'b0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            if (m_done) begin
                done_seen = 1'b1;
            end else begin
                if (poke_run && m_run && !poked) begin
                    poked = 1'b1;
                    if (use_b) start_b = 1'b1; else start_a = 1'b1;
                end
                tick();
                start_a = 1'b0; start_b = 1'b0;
            end
        end
        n_chk++;
        if (!done_seen) begin n_bad++; $display("FAIL %s_done_timeout got=0 exp=1", nm); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_chk++; if ({a_ready, a_crst, a_run, a_busy, a_done, a_err} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=000000", {a_ready, a_crst, a_run, a_busy, a_done, a_err}); end
        n_chk++; if (a_addr !== '0 || a_data !== '0) begin n_bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", a_addr, a_data); end
        n_chk++; if (a_wc !== 16'd0) begin n_bad++; $display("FAIL reset_wc got=%0d exp=0", a_wc); end
        n_chk++; if ({b_ready, b_crst, b_busy, b_done} !== 4'b0) begin n_bad++; $display("FAIL reset_b_flags got=%b exp=0000", {b_ready, b_crst, b_busy, b_done}); end
        @(negedge clk);
        reset_n = 1'b1;
        tick(); tick();
        n_chk++; if (a_busy !== 1'b0 || a_crst !== 1'b0) begin n_bad++; $display("FAIL reset_idle got=%b%b exp=00", a_busy, a_crst); end
    endtask

    task automatic test_basic();
        int s; logic e0; logic [15:0] w0;
        logic [31:0] ea[3]; logic [31:0] ed[3];
        ea = '{32'h00010002, 32'h00020003, 32'h00030004};
        ed = '{32'h0000000A, 32'h0000000B, 32'h0000000C};
        for (int i = 0; i < 3; i++) begin tw_addr[i] = ea[i]; tw_data[i] = ed[i]; end
        run_seq("basic", 1'b0, 32'd10, 3, 6'h3F, 1'b0, s, e0, w0);
        n_chk++; if (rst_cnt != 4 || rst_first != s + 1) begin n_bad++; $display("FAIL basic_crst got=%0d@%0d exp=4@%0d", rst_cnt, rst_first, s + 1); end
        n_chk++; if (wr_cyc.size() != 3) begin n_bad++; $display("FAIL basic_nwr got=%0d exp=3", wr_cyc.size()); end
        for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
            n_chk++;
            if (wr_cyc[i] != s + 6 + i || wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
                n_bad++;
                $display("FAIL basic_wr%0d got=%0d:%h/%h exp=%0d:%h/%h", i, wr_cyc[i], wr_addr[i], wr_data[i], s + 6 + i, ea[i], ed[i]);
            end
        end
        n_chk++; if (run_cnt != 10 || run_first != s + 9) begin n_bad++; $display("FAIL basic_run got=%0d@%0d exp=10@%0d", run_cnt, run_first, s + 9); end
        n_chk++; if (a_done !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0) begin n_bad++; $display("FAIL basic_done got=%b%b%b exp=100", a_done, a_busy, a_ready); end
        n_chk++; if (a_wc !== 16'd3 || a_err !== 1'b0) begin n_bad++; $display("FAIL basic_wc_err got=%0d/%b exp=3/0", a_wc, a_err); end
    endtask

    task automatic test_gap();
        int s; logic e0; logic [15:0] w0;
        logic [31:0] ea[3]; int eo[3];
        ea = '{32'h00010002, 32'h00020003, 32'h00030004};
        eo = '{6, 9, 12};
        for (int i = 0; i < 3; i++) begin tw_addr[i] = ea[i]; tw_data[i] = 32'(i + 1); end
        run_seq("gap", 1'b1, 32'd2, 3, 6'h3F, 1'b0, s, e0, w0);
        n_chk++; if (wr_cyc.size() != 3) begin n_bad++; $display("FAIL gap_nwr got=%0d exp=3", wr_cyc.size()); end
        for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
            n_chk++;
            if (wr_cyc[i] != s + eo[i] || wr_addr[i] !== ea[i] || wr_data[i] !== 32'(i + 1)) begin
                n_bad++;
                $display("FAIL gap_wr%0d got=%0d:%h/%h exp=%0d:%h/%h", i, wr_cyc[i], wr_addr[i], wr_data[i], s + eo[i], ea[i], 32'(i + 1));
            end
        end
        n_chk++; if (rdy_cyc.size() != 3) begin n_bad++; $display("FAIL gap_nready got=%0d exp=3", rdy_cyc.size()); end
        for (int i = 0; i < 3 && i < rdy_cyc.size(); i++) begin
            n_chk++;
            if (rdy_cyc[i] != s + 5 + 3 * i) begin n_bad++; $display("FAIL gap_ready%0d got=%0d exp=%0d", i, rdy_cyc[i], s + 5 + 3 * i); end
        end
        n_chk++; if (run_cnt != 2 || b_wc !== 16'd3) begin n_bad++; $display("FAIL gap_run_wc got=%0d/%0d exp=2/3", run_cnt, b_wc); end
    endtask

    task automatic test_zero_addr();
        int s; logic e0; logic [15:0] w0;
        tw_addr[0] = 32'h11; tw_data[0] = 32'h1;
        tw_addr[1] = 32'h00; tw_data[1] = 32'h2;
        tw_addr[2] = 32'h33; tw_data[2] = 32'h3;
        run_seq("zero", 1'b0, 32'd1, 3, 6'h3F, 1'b0, s, e0, w0);
        n_chk++; if (wr_cyc.size() != 2) begin n_bad++; $display("FAIL zero_nwr got=%0d exp=2", wr_cyc.size()); end
        if (wr_cyc.size() == 2) begin
            n_chk++;
            if (wr_cyc[0] != s + 6 || wr_addr[0] !== 32'h11 || wr_cyc[1] != s + 8 || wr_addr[1] !== 32'h33 || wr_data[1] !== 32'h3) begin
                n_bad++;
                $display("FAIL zero_wr got=%0d:%h %0d:%h/%h exp=%0d:11 %0d:33/3", wr_cyc[0], wr_addr[0], wr_cyc[1], wr_addr[1], wr_data[1], s + 6, s + 8);
            end
        end
        n_chk++; if (a_err !== 1'b1 || a_wc !== 16'd2) begin n_bad++; $display("FAIL zero_err_wc got=%b/%0d exp=1/2", a_err, a_wc); end
        repeat (3) tick();
        n_chk++; if (a_err !== 1'b1 || a_done !== 1'b1) begin n_bad++; $display("FAIL zero_sticky got=%b/%b exp=1/1", a_err, a_done); end
        tw_addr[0] = 32'h44; tw_data[0] = 32'h4;
        run_seq("zero_rerun", 1'b0, 32'd1, 1, 6'h3F, 1'b0, s, e0, w0);
        n_chk++; if (e0 !== 1'b0 || w0 !== 16'd0) begin n_bad++; $display("FAIL zero_clear_on_start got=%b/%0d exp=0/0", e0, w0); end
        n_chk++; if (a_err !== 1'b0 || a_wc !== 16'd1) begin n_bad++; $display("FAIL zero_rerun_end got=%b/%0d exp=0/1", a_err, a_wc); end
    endtask

    task automatic test_backpressure();
        int s; logic e0; logic [15:0] w0;
        int eo[3];
        eo = '{6, 9, 11};
        for (int i = 0; i < 3; i++) begin tw_addr[i] = 32'(32'h101 * (i + 1)); tw_data[i] = 32'(i + 1); end
        run_seq("bp", 1'b0, 32'd3, 3, 6'b101001, 1'b0, s, e0, w0);
        n_chk++; if (wr_cyc.size() != 3) begin n_bad++; $display("FAIL bp_nwr got=%0d exp=3", wr_cyc.size()); end
        for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
            n_chk++;
            if (wr_cyc[i] != s + eo[i] || wr_addr[i] !== 32'(32'h101 * (i + 1)) || wr_data[i] !== 32'(i + 1)) begin
                n_bad++;
                $display("FAIL bp_wr%0d got=%0d:%h/%h exp=%0d:%h/%h", i, wr_cyc[i], wr_addr[i], wr_data[i], s + eo[i], 32'(32'h101 * (i + 1)), 32'(i + 1));
            end
        end
        n_chk++; if (run_cnt != 3 || run_first != s + 12) begin n_bad++; $display("FAIL bp_run got=%0d@%0d exp=3@%0d", run_cnt, run_first, s + 12); end
    endtask

    task automatic test_run_zero_restart();
        int s; logic e0; logic [15:0] w0;
        tw_addr[0] = 32'h55; tw_data[0] = 32'h5;
        tw_addr[1] = 32'h66; tw_data[1] = 32'h6;
        run_seq("run0", 1'b0, 32'd0, 2, 6'h3F, 1'b0, s, e0, w0);
        n_chk++; if (run_cnt != 0) begin n_bad++; $display("FAIL run0_run_en got=%0d exp=0", run_cnt); end
        n_chk++; if (a_done !== 1'b1 || a_wc !== 16'd2 || wr_cyc.size() != 2) begin n_bad++; $display("FAIL run0_end got=%b/%0d/%0d exp=1/2/2", a_done, a_wc, wr_cyc.size()); end
        tw_addr[0] = 32'h77; tw_data[0] = 32'h7;
        run_seq("restart", 1'b0, 32'd5, 1, 6'h3F, 1'b1, s, e0, w0);
        n_chk++; if (rst_cnt != 4 || rst_first != s + 1) begin n_bad++; $display("FAIL restart_crst got=%0d@%0d exp=4@%0d", rst_cnt, rst_first, s + 1); end
        n_chk++; if (run_cnt != 5 || run_first != s + 7) begin n_bad++; $display("FAIL restart_run got=%0d@%0d exp=5@%0d", run_cnt, run_first, s + 7); end
        n_chk++; if (wr_cyc.size() != 1 || a_wc !== 16'd1) begin n_bad++; $display("FAIL restart_wr got=%0d/%0d exp=1/1", wr_cyc.size(), a_wc); end
    endtask

    task automatic test_mid_reset();
        int s; logic e0; logic [15:0] w0;
        sel = 1'b0;
        run_cycles = 32'd5;
        cfg_addr = 32'h00010002; cfg_data = 32'hA; cfg_last = 1'b0; cfg_valid = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        cfg_addr = 32'h00020003; cfg_data = 32'hB;
        tick();
        cfg_addr = 32'h00030004; cfg_data = 32'hC; cfg_last = 1'b1;
        n_chk++; if (a_addr !== 32'h00020003 || a_data !== 32'hB) begin n_bad++; $display("FAIL midrst_pre got=%h/%h exp=00020003/0000000b", a_addr, a_data); end
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (a_addr !== '0 || a_data !== '0) begin n_bad++; $display("FAIL midrst_bus got=%h/%h exp=0/0", a_addr, a_data); end
        n_chk++; if ({a_ready, a_crst, a_run, a_busy, a_done, a_err} !== 6'b0 || a_wc !== 16'd0) begin n_bad++; $display("FAIL midrst_flags got=%b/%0d exp=000000/0", {a_ready, a_crst, a_run, a_busy, a_done, a_err}, a_wc); end
        cfg_valid = 1'b0; cfg_last = 1'b0; cfg_addr = '0; cfg_data = '0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tw_addr[0] = 32'h00010002; tw_data[0] = 32'hA;
        tw_addr[1] = 32'h00020003; tw_data[1] = 32'hB;
        tw_addr[2] = 32'h00030004; tw_data[2] = 32'hC;
        run_seq("midrst_fresh", 1'b0, 32'd2, 3, 6'h3F, 1'b0, s, e0, w0);
        n_chk++; if (rst_cnt != 4 || wr_cyc.size() != 3 || run_cnt != 2) begin n_bad++; $display("FAIL midrst_fresh_seq got=%0d/%0d/%0d exp=4/3/2", rst_cnt, wr_cyc.size(), run_cnt); end
        if (wr_cyc.size() == 3) begin
            n_chk++; if (wr_cyc[0] != s + 6 || wr_addr[2] !== 32'h00030004) begin n_bad++; $display("FAIL midrst_fresh_wr got=%0d/%h exp=%0d/00030004", wr_cyc[0], wr_addr[2], s + 6); end
        end
        n_chk++; if (a_wc !== 16'd3 || a_done !== 1'b1) begin n_bad++; $display("FAIL midrst_fresh_end got=%0d/%b exp=3/1", a_wc, a_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_zero_addr();
        test_backpressure();
        test_run_zero_restart();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cgra_config_sequencer.md
Name: cgra_config_sequencer

Overview:
Drives the CGRA top-level config bus (config_addr_in/config_data_in) and its reset from an upstream stream of address/data pairs. Sequences a full bring-up: CGRA reset pulse, configuration write burst, a run window of programmable length, then done. Replaces bench-side, file-driven config loading, so the same bring-up runs in simulation and on an FPGA wrapper.

Parameters:
ADDR_W, 32, config address width
DATA_W, 32, config data width
RST_CYCLES, 4, cycles cgra_reset_out is held high (min 1)
GAP_CYCLES, 0, idle cycles inserted after each config write (0..15)
RUN_W, 32, width of run-cycle counter

Ports:
clk_in  input  1  system clock, all logic on rising edge
reset_n_in  input  1  asynchronous active-low reset
start_in  input  1  1-cycle pulse; begins a sequence when in IDLE or DONE
run_cycles_in  input  RUN_W  run window length; sampled on accepted start
cfg_valid_in  input  1  config word valid
cfg_ready_out  output  1  sequencer accepts word this cycle
cfg_addr_in  input  ADDR_W  config address
cfg_data_in  input  DATA_W  config data
cfg_last_in  input  1  marks final word of burst
cgra_reset_out  output  1  active-high reset to CGRA (reset_in)
config_addr_out  output  ADDR_W  to CGRA config_addr_in; 0 when no write
config_data_out  output  DATA_W  to CGRA config_data_in; 0 when no write
run_en_out  output  1  high during run window
busy_out  output  1  high in any state except IDLE/DONE
done_out  output  1  high in DONE
err_out  output  1  sticky: zero-address word received; cleared on start
word_count_out  output  16  config words written this sequence (saturating)

Behaviour:
- Reset (async, reset_n_in low): state IDLE; all outputs 0, except cfg_ready_out 0 and cgra_reset_out 0; counters 0.
- States: IDLE, CRST, CONFIG, GAP, RUN, DONE.
- IDLE/DONE + start_in: latch run_cycles_in; clear err_out and word_count_out; go to CRST. start_in is ignored in any other state.
- CRST: cgra_reset_out=1 for exactly RST_CYCLES cycles, then CONFIG. The first cycle of cgra_reset_out is the cycle after start.
- CONFIG: cfg_ready_out=1 (combinational from state only, never from cfg_valid_in). On handshake (valid&ready) at cycle t:
  - Address nonzero: config_addr_out/config_data_out = word during cycle t+1 only; otherwise both 0. word_count_out increments.
  - Address zero: word is consumed and not driven; err_out set; no count. Zero is the bus idle value, so it can never be a real write.
  - After handshake: go to GAP if GAP_CYCLES>0, else stay in CONFIG (back-to-back writes allowed, one per cycle).
  - cfg_last_in on handshake: go to RUN instead, after the final write's output cycle. GAP is not inserted after the last word.
- GAP: cfg_ready_out=0 for GAP_CYCLES cycles, then CONFIG.
- RUN: run_en_out=1 for exactly the latched run_cycles cycles, then DONE. With latched value 0, RUN lasts 0 cycles: go directly to DONE.
- DONE: done_out=1, held until the next start_in. Outputs zero except done_out, err_out and word_count_out.
- word_count_out saturates at 0xFFFF.
- Async reset mid-sequence: everything aborts to IDLE immediately; the config bus returns to 0 the same instant.
- cgra_reset_out and all config outputs are registered (glitch-free into CGRA).

Decomposition:
- Package cgra_cfg_pkg: state enum (seq_state_t), CFG_IDLE_ADDR = 0, default widths.
- One sub-module: cgra_cfg_down_counter (load value, decrement, zero flag), instanced for CRST, GAP and RUN timing.
- FSM and config-bus output registers stay in the top module.

Test Plan:
- Basic burst: RST_CYCLES=4, GAP=0, start with run_cycles=10, push 3 words (0x00010002/0xA, 0x00020003/0xB, last 0x00030004/0xC), valid held high.
  - cgra_reset_out high exactly 4 cycles.
  - Three consecutive config cycles with the exact pairs, bus 0 before and after.
  - run_en_out high 10 cycles; then done_out=1, word_count_out=3, err_out=0.
- Gap spacing: GAP_CYCLES=2, 3 words, valid always high.
  - Writes spaced 3 cycles apart; cfg_ready_out low 2 cycles after each non-last handshake.
- Zero address: second of 3 words has addr 0.
  - Only 2 bus writes; err_out=1 sticky through DONE; word_count_out=2.
  - err_out cleared by the next start.
- Backpressure from source: cfg_valid_in toggles 1,0,0,1,0,1(last).
  - Bus writes only on the cycle after each handshake; no spurious nonzero address.
- run_cycles=0 and restart: sequence goes CONFIG→DONE with run_en_out never high.
  - start in DONE reruns the full sequence; start pulsed during RUN is ignored.
- Mid-sequence reset: assert reset_n_in low during the second config write.
  - All outputs 0 immediately (async, before the next clock edge); state IDLE; a fresh start sequences correctly.
